// File: rtl/sigma_delta_frame_ctrl.sv
// Frame sequencer for the sigma-delta background model datapath.
// Streams pixels through RAM read, datapath and RAM write-back.
module sigma_delta_frame_ctrl #(
   parameter int         FRAME_PIXELS = 76800,
   parameter int         ADDR_W       = 17,
   parameter logic [7:0] VAR_INIT     = 8'd2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_req,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sof,
   input  logic [7:0]        in_pixel,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [7:0]        mem_rd_bg,
   input  logic [7:0]        mem_rd_var,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [7:0]        mem_wr_bg,
   output logic [7:0]        mem_wr_var,
   output logic              sd_enable,
   output logic              sd_wr_background,
   output logic [7:0]        sd_curr_pixel,
   output logic [7:0]        sd_background,
   output logic [7:0]        sd_variance,
   input  logic [7:0]        sd_background_next,
   input  logic [7:0]        sd_variance_next,
   input  logic              sd_motion,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_motion,
   output logic              out_sof,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, INIT, RUN, DRAIN} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

   state_t            state;
   state_t            state_nxt;
   logic              init_pend;
   logic [ADDR_W-1:0] pix_cnt;
   logic              stall;
   logic              accept;
   logic              start;
   logic              take;
   logic              last;
   logic              frame_init;
   logic              s1_valid;
   logic              s1_init;
   logic              s1_sof;
   logic [7:0]        s1_pixel;
   logic [ADDR_W-1:0] s1_addr;

   assign stall      = out_valid && !out_ready;
   assign in_ready   = !stall && (state != DRAIN);
   assign accept     = in_valid && in_ready && !rst;
   assign start      = accept && in_sof && (state == IDLE);
   assign take       = start ||
                       (accept && !in_sof &&
                        (state == INIT || state == RUN));
   assign last       = take && !start && (pix_cnt == LAST_ADDR);
   assign frame_init = (state == IDLE) ? init_pend : (state == INIT);

   assign mem_rd_en   = take;
   assign mem_rd_addr = (take && !start) ? pix_cnt : '0;

   assign sd_enable        = s1_valid && !stall;
   assign sd_wr_background = s1_valid && s1_init;
   assign sd_curr_pixel    = s1_valid ? s1_pixel : 8'd0;
   assign sd_background    = s1_valid ? mem_rd_bg : 8'd0;
   assign sd_variance      = s1_valid ? mem_rd_var : 8'd0;

   assign busy = (state != IDLE) || s1_valid || out_valid;

   // Frame state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Frame sequencing: start on sof, drain after the last pixel
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (start) state_nxt = init_pend ? INIT : RUN;
         INIT, RUN: if (last) state_nxt = DRAIN;
         DRAIN:     if (!s1_valid && !out_valid) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Pending init request and pixel address counter
   always_ff @(posedge clk) begin
      if (rst) begin
         init_pend <= 1'b1;
         pix_cnt   <= '0;
      end else begin
         if (init_req)                init_pend <= 1'b1;
         else if (start && init_pend) init_pend <= 1'b0;
         if (start)      pix_cnt <= ADDR_W'(1);
         else if (last)  pix_cnt <= '0;
         else if (take)  pix_cnt <= pix_cnt + ADDR_W'(1);
      end
   end

   // S1: pixel waits here while the RAM returns its model data
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_init  <= 1'b0;
         s1_sof   <= 1'b0;
         s1_pixel <= 8'd0;
         s1_addr  <= '0;
      end else if (!stall) begin
         s1_valid <= take;
         s1_init  <= take && frame_init;
         s1_sof   <= start;
         s1_pixel <= take ? in_pixel : 8'd0;
         s1_addr  <= mem_rd_addr;
      end
   end

   // S2: write-back strobe fires once; output data holds under stall
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_bg   <= 8'd0;
         mem_wr_var  <= 8'd0;
         out_valid   <= 1'b0;
         out_motion  <= 1'b0;
         out_sof     <= 1'b0;
      end else begin
         mem_wr_en <= sd_enable;
         if (!stall) begin
            out_valid   <= s1_valid;
            out_motion  <= s1_valid && !s1_init && sd_motion;
            out_sof     <= s1_valid && s1_sof;
            mem_wr_addr <= s1_addr;
            mem_wr_bg   <= s1_valid ? sd_background_next : 8'd0;
            mem_wr_var  <= !s1_valid ? 8'd0 :
                           s1_init ? VAR_INIT : sd_variance_next;
         end
      end
   end

endmodule

// File: tb/tb_sigma_delta_frame_ctrl.sv
// Bench for sigma_delta_frame_ctrl with RAM and datapath stubs.
// Scoreboard queues hold expected writes, outputs and datapath calls.
module tb_sigma_delta_frame_ctrl;

   localparam int FP = 4;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst;
   logic          init_req;
   logic          in_valid;
   logic          in_ready;
   logic          in_sof;
   logic [7:0]    in_pixel;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [7:0]    mem_rd_bg;
   logic [7:0]    mem_rd_var;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [7:0]    mem_wr_bg;
   logic [7:0]    mem_wr_var;
   logic          sd_enable;
   logic          sd_wr_background;
   logic [7:0]    sd_curr_pixel;
   logic [7:0]    sd_background;
   logic [7:0]    sd_variance;
   logic [7:0]    sd_background_next;
   logic [7:0]    sd_variance_next;
   logic          sd_motion;
   logic          out_valid;
   logic          out_ready;
   logic          out_motion;
   logic          out_sof;
   logic          busy;

   always #5 clk = ~clk;

   sigma_delta_frame_ctrl #(
      .FRAME_PIXELS(FP),
      .ADDR_W(AW),
      .VAR_INIT(8'd2)
   ) dut (
      .clk(clk), .rst(rst), .init_req(init_req),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sof(in_sof), .in_pixel(in_pixel),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_bg(mem_rd_bg), .mem_rd_var(mem_rd_var),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_wr_bg(mem_wr_bg), .mem_wr_var(mem_wr_var),
      .sd_enable(sd_enable), .sd_wr_background(sd_wr_background),
      .sd_curr_pixel(sd_curr_pixel), .sd_background(sd_background),
      .sd_variance(sd_variance),
      .sd_background_next(sd_background_next),
      .sd_variance_next(sd_variance_next), .sd_motion(sd_motion),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_motion(out_motion), .out_sof(out_sof), .busy(busy)
   );

   // Datapath stub; init mode returns a bogus variance and motion
   // so the controller's overrides are visible
   function automatic logic [16:0] dp(input logic wrb,
         input logic [7:0] p, input logic [7:0] bg,
         input logic [7:0] vr);
      logic [7:0] d, bn, vn;
      if (wrb) return {p, 8'hEE, 1'b1};
      d  = (p > bg) ? p - bg : bg - p;
      bn = (p > bg) ? bg + 8'd1 : (p < bg) ? bg - 8'd1 : bg;
      vn = (d > vr) ? vr + 8'd1 : (d < vr) ? vr - 8'd1 : vr;
      return {bn, vn, d > vr};
   endfunction

   always_comb begin
      {sd_background_next, sd_variance_next, sd_motion} =
         dp(sd_wr_background, sd_curr_pixel, sd_background, sd_variance);
   end

   // Model RAM: registered read data held between read strobes
   logic [7:0] ram_bg [FP];
   logic [7:0] ram_var [FP];
   logic       clear;
   always @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < FP; i++) begin
            ram_bg[i]  <= 8'h55;
            ram_var[i] <= 8'h07;
         end
         mem_rd_bg  <= 8'd0;
         mem_rd_var <= 8'd0;
      end else begin
         if (mem_rd_en) begin
            mem_rd_bg  <= ram_bg[int'(mem_rd_addr) % FP];
            mem_rd_var <= ram_var[int'(mem_rd_addr) % FP];
         end
         if (mem_wr_en) begin
            ram_bg[int'(mem_wr_addr) % FP]  <= mem_wr_bg;
            ram_var[int'(mem_wr_addr) % FP] <= mem_wr_var;
         end
      end
   end

   typedef struct packed {
      logic [AW-1:0] a;
      logic [7:0]    bg;
      logic [7:0]    vr;
   } wr_t;
   typedef struct packed {
      logic m;
      logic s;
   } out_t;
   typedef struct packed {
      logic       ini;
      logic [7:0] pix;
      logic [7:0] bg;
      logic [7:0] vr;
   } sd_t;
   typedef struct {
      logic       sof;
      logic [7:0] pix;
      logic       proc;
      logic       ini;
      int         a;
   } vec_t;

   wr_t  wq [$];
   out_t oq [$];
   sd_t  sq [$];
   vec_t tbl [$];
   logic [7:0] rbg [FP];
   logic [7:0] rvar [FP];
   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t",
                    nm, act, exp, $time);
   endtask

   // Scoreboard: pop expectations as the DUT produces them
   wr_t  wcur;
   out_t ocur;
   sd_t  scur;
   always @(negedge clk) begin
      if (mem_wr_en) begin
         if (wq.size() == 0) chk("wr_unexpected", 1, 0);
         else begin
            wcur = wq.pop_front();
            chk("wr_addr", mem_wr_addr, wcur.a);
            chk("wr_bg", mem_wr_bg, wcur.bg);
            chk("wr_var", mem_wr_var, wcur.vr);
         end
      end
      if (out_valid && out_ready) begin
         if (oq.size() == 0) chk("out_unexpected", 1, 0);
         else begin
            ocur = oq.pop_front();
            chk("out_motion", out_motion, ocur.m);
            chk("out_sof", out_sof, ocur.s);
         end
      end
      if (sd_enable) begin
         if (sq.size() == 0) chk("sd_unexpected", 1, 0);
         else begin
            scur = sq.pop_front();
            chk("sd_wr_background", sd_wr_background, scur.ini);
            chk("sd_curr_pixel", sd_curr_pixel, scur.pix);
            chk("sd_background", sd_background, scur.bg);
            chk("sd_variance", sd_variance, scur.vr);
         end
      end
   end

   task automatic add(input logic sof, input logic [7:0] pix,
         input logic proc, input logic ini, input int a);
      vec_t v;
      v.sof = sof; v.pix = pix; v.proc = proc; v.ini = ini; v.a = a;
      tbl.push_back(v);
   endtask

   // Drive one pixel until accepted; queue expectations if used
   task automatic send(input logic sof, input logic [7:0] pix,
         input logic proc, input logic ini, input int a);
      logic [16:0] r;
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1; in_sof = sof; in_pixel = pix;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("in_ready_timeout", 0, 1);
      chk("rd_en", mem_rd_en, proc);
      if (proc) begin
         chk("rd_addr", mem_rd_addr, a);
         r = dp(ini, pix, rbg[a], rvar[a]);
         sq.push_back('{ini, pix, rbg[a], rvar[a]});
         wq.push_back('{AW'(a), r[16:9], ini ? 8'd2 : r[8:1]});
         oq.push_back('{ini ? 1'b0 : r[0], sof});
         rbg[a]  = r[16:9];
         rvar[a] = ini ? 8'd2 : r[8:1];
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0; in_sof = 1'b0;
      end
   endtask

   initial begin
      clear = 1'b1; rst = 1'b1; init_req = 1'b0;
      in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'd0;
      out_ready = 1'b1;
      for (int i = 0; i < FP; i++) begin
         rbg[i] = 8'h55; rvar[i] = 8'h07;
      end
      // frame 1: init frame after reset
      add(1, 10, 1, 1, 0); add(0, 20, 1, 1, 1);
      add(0, 30, 1, 1, 2); add(0, 40, 1, 1, 3);
      // idle drops, then frame 2 (run) with a stray sof
      add(0, 99, 0, 0, 0); add(0, 77, 0, 0, 0);
      add(1, 50, 1, 0, 0); add(0, 22, 1, 0, 1);
      add(1, 5, 0, 0, 0);  add(0, 33, 1, 0, 2);
      add(0, 45, 1, 0, 3);
      // frame 4: init frame requested during frame 3
      add(1, 60, 1, 1, 0); add(0, 70, 1, 1, 1);
      add(0, 80, 1, 1, 2); add(0, 90, 1, 1, 3);
      // frame 6: init after reset; frame 7: run
      add(1, 1, 1, 1, 0); add(0, 2, 1, 1, 1);
      add(0, 3, 1, 1, 2); add(0, 4, 1, 1, 3);
      add(1, 9, 1, 0, 0); add(0, 2, 1, 0, 1);
      add(0, 0, 1, 0, 2); add(0, 200, 1, 0, 3);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_sd_enable", sd_enable, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_wr_addr", mem_wr_addr, 0);
      @(posedge clk); #1;
      clear = 1'b0; rst = 1'b0;

      for (int i = 0; i < 11; i++)
         send(tbl[i].sof, tbl[i].pix, tbl[i].proc, tbl[i].ini, tbl[i].a);

      // frame 3: run; stall output 3 cycles, request init
      send(1, 11, 1, 0, 0);
      send(0, 21, 1, 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0; init_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_sd_enable", sd_enable, 0);
         chk("stall_out_valid", out_valid, 1);
         @(posedge clk); #1;
         init_req = 1'b0;
      end
      out_ready = 1'b1;
      send(1, 99, 0, 0, 0);
      send(0, 31, 1, 0, 2);
      send(0, 41, 1, 0, 3);

      for (int i = 11; i < 15; i++)
         send(tbl[i].sof, tbl[i].pix, tbl[i].proc, tbl[i].ini, tbl[i].a);

      // frame 5: reset after two pixels
      send(1, 5, 1, 0, 0);
      send(0, 6, 1, 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rrst_wr_en", mem_wr_en, 0);
      chk("rrst_out_valid", out_valid, 0);
      chk("rrst_sd_enable", sd_enable, 0);
      chk("rrst_busy", busy, 0);
      chk("rrst_wr_left", wq.size(), 1);
      chk("rrst_out_left", oq.size(), 1);
      wq.delete(); oq.delete(); sq.delete();
      for (int i = 0; i < FP; i++) begin
         rbg[i] = ram_bg[i]; rvar[i] = ram_var[i];
      end

      for (int i = 15; i < 23; i++)
         send(tbl[i].sof, tbl[i].pix, tbl[i].proc, tbl[i].ini, tbl[i].a);
      idle(1);

      for (int n = 0; n < 40 && busy; n++) @(negedge clk);
      @(negedge clk);
      chk("end_busy", busy, 0);
      chk("end_wq_empty", wq.size(), 0);
      chk("end_oq_empty", oq.size(), 0);
      chk("end_sq_empty", sq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
